// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction prefetch front-end.
// The FIFO entry carries the fetch PC alongside the returned instruction word.
package ifetch_pkg;

  localparam int          INST_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fifo_entry_t;

  function automatic logic [INST_W-1:0] align_pc(input logic [INST_W-1:0] pc);
    return {pc[INST_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer of {pc, inst} entries with flush; head is read straight from storage.
// Flush takes priority over push and pop; pop on empty is ignored.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fifo_entry_t   push_data,
  input  logic          pop,
  input  logic          flush,
  output fifo_entry_t   head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_fire;
  logic          push_fire;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign pop_fire  = pop && !empty;
  // a full buffer still accepts a push when the head leaves in the same cycle
  assign push_fire = push && (!full || pop_fire);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push_fire) - CW'(pop_fire);
    end
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch front-end: issues imem reads, buffers {pc, inst}, and handles redirects.
// A redirect never abandons an outstanding request; its response is dropped instead.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  if_state_e     state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   drop_addr, drop_addr_next;
  logic [31:0]   redir_pc;
  logic          push;
  logic          pop_fire;
  fifo_entry_t   push_data;
  fifo_entry_t   head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [CW:0]   count_after;
  logic          room_after;

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (inst_ready),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign inst_valid = !empty;
  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;
  assign pop_fire   = inst_valid && inst_ready;
  assign redir_pc   = align_pc(redirect_pc);
  assign push_data  = '{pc: fetch_pc, inst: imem_rdata};

  // occupancy after a push this cycle decides whether to keep a request outstanding
  assign count_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop_fire);
  assign room_after  = (count_after < (CW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IF_IDLE;
      fetch_pc  <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      drop_addr <= drop_addr_next;
    end
  end

  always_comb begin
    state_next     = state;
    fetch_pc_next  = fetch_pc;
    drop_addr_next = drop_addr;
    imem_req       = 1'b0;
    imem_addr      = fetch_pc;
    push           = 1'b0;
    unique case (state)
      IF_IDLE: begin
        if (redirect_valid) begin
          fetch_pc_next = redir_pc;
        end else if (!full) begin
          imem_req = rst_n;
          if (imem_ack && rst_n) begin
            push          = 1'b1;
            fetch_pc_next = fetch_pc + PC_INC;
            state_next    = room_after ? IF_WAIT : IF_IDLE;
          end else begin
            state_next = IF_WAIT;
          end
        end
      end
      IF_WAIT: begin
        imem_req = rst_n;
        if (redirect_valid) begin
          fetch_pc_next  = redir_pc;
          drop_addr_next = fetch_pc;
          state_next     = imem_ack ? IF_IDLE : IF_DROP;
        end else if (imem_ack) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc + PC_INC;
          state_next    = room_after ? IF_WAIT : IF_IDLE;
        end
      end
      IF_DROP: begin
        // keep presenting the abandoned address until memory completes it
        imem_req  = rst_n;
        imem_addr = drop_addr;
        if (redirect_valid) begin
          fetch_pc_next = redir_pc;
        end
        if (imem_ack) begin
          state_next = IF_IDLE;
        end
      end
      default: begin
        state_next = IF_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: a vector table for streaming/backpressure,
// then hand-written sequences for redirect, drop, alignment, wrap and reset corners.
module tb_ifetch_prefetch;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifetch_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  typedef struct {
    logic        rst_n;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // inputs change at the falling edge; outputs are sampled 1ns later
  task automatic drive(input logic r, input logic a, input logic [31:0] d,
                       input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    rst_n          = r;
    imem_ack       = a;
    imem_rdata     = d;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic add(input logic r, input logic a, input logic [31:0] d, input logic rdy,
                     input logic e_req, input logic [31:0] e_addr, input logic e_v,
                     input logic [31:0] e_pc, input logic [31:0] e_data);
    vec_t v;
    v = '{rst_n: r, ack: a, rdata: d, ready: rdy, rv: 1'b0, rpc: 32'h0,
          exp_req: e_req, exp_addr: e_addr, exp_valid: e_v, exp_pc: e_pc, exp_data: e_data};
    vq.push_back(v);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

    // streaming with zero-wait memory, then backpressure until full and release
    add(0, 0, 32'h0,           1, 0, 32'h00, 0, 32'h00, 32'h0);
    add(1, 1, 32'h00 ^ K,      1, 1, 32'h00, 0, 32'h00, 32'h0);
    add(1, 1, 32'h04 ^ K,      1, 1, 32'h04, 1, 32'h00, 32'h00 ^ K);
    add(1, 1, 32'h08 ^ K,      1, 1, 32'h08, 1, 32'h04, 32'h04 ^ K);
    add(1, 1, 32'h0C ^ K,      1, 1, 32'h0C, 1, 32'h08, 32'h08 ^ K);
    add(1, 0, 32'h0,           1, 1, 32'h10, 1, 32'h0C, 32'h0C ^ K);
    add(1, 0, 32'h0,           1, 1, 32'h10, 0, 32'h00, 32'h0);
    add(1, 1, 32'h10 ^ K,      0, 1, 32'h10, 0, 32'h00, 32'h0);
    add(1, 1, 32'h14 ^ K,      0, 1, 32'h14, 1, 32'h10, 32'h10 ^ K);
    add(1, 1, 32'h18 ^ K,      0, 1, 32'h18, 1, 32'h10, 32'h10 ^ K);
    add(1, 1, 32'h1C ^ K,      0, 1, 32'h1C, 1, 32'h10, 32'h10 ^ K);
    add(1, 1, 32'hDEAD_0000,   0, 0, 32'h20, 1, 32'h10, 32'h10 ^ K);
    add(1, 0, 32'h0,           1, 0, 32'h20, 1, 32'h10, 32'h10 ^ K);
    add(1, 0, 32'h0,           1, 1, 32'h20, 1, 32'h14, 32'h14 ^ K);
    add(1, 0, 32'h0,           1, 1, 32'h20, 1, 32'h18, 32'h18 ^ K);
    add(1, 0, 32'h0,           1, 1, 32'h20, 1, 32'h1C, 32'h1C ^ K);
    add(1, 0, 32'h0,           1, 1, 32'h20, 0, 32'h00, 32'h0);

    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst_n, vq[i].ack, vq[i].rdata, vq[i].ready, vq[i].rv, vq[i].rpc);
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vq[i].exp_req));
      chk($sformatf("v%0d_addr", i), imem_addr, vq[i].exp_addr);
      chk($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(vq[i].exp_valid));
      if (vq[i].exp_valid || !vq[i].rst_n) begin
        chk($sformatf("v%0d_pc", i), inst_pc, vq[i].exp_pc);
        chk($sformatf("v%0d_data", i), inst_data, vq[i].exp_data);
      end
    end

    // redirect one cycle after req on slow memory: request held, data dropped
    do_reset();
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    chk("lat_req0", 32'(imem_req), 32'd1);
    drive(1, 0, 32'h0, 1, 1, 32'h40);
    chk("lat_addr1", imem_addr, 32'h0);
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    chk("lat_hold_req", 32'(imem_req), 32'd1);
    chk("lat_hold_addr", imem_addr, 32'h0);
    drive(1, 1, 32'hDEAD_BEEF, 1, 0, 32'h0);
    chk("lat_ack_addr", imem_addr, 32'h0);
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    chk("lat_no_push", 32'(inst_valid), 32'd0);
    chk("lat_new_addr", imem_addr, 32'h40);
    chk("lat_new_req", 32'(imem_req), 32'd1);
    drive(1, 1, 32'h40 ^ K, 1, 0, 32'h0);
    chk("lat_addr40", imem_addr, 32'h40);
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    chk("lat_valid", 32'(inst_valid), 32'd1);
    chk("lat_pc", inst_pc, 32'h40);
    chk("lat_data", inst_data, 32'h40 ^ K);

    // redirect coincident with ack and pop, two entries buffered
    do_reset();
    drive(1, 1, 32'h00 ^ K, 0, 0, 32'h0);
    drive(1, 1, 32'h04 ^ K, 0, 0, 32'h0);
    drive(1, 1, 32'h08 ^ K, 1, 1, 32'h20);
    chk("flush_head_pc", inst_pc, 32'h0);
    chk("flush_addr8", imem_addr, 32'h8);
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    chk("flush_empty", 32'(inst_valid), 32'd0);
    chk("flush_addr", imem_addr, 32'h20);
    chk("flush_req", 32'(imem_req), 32'd1);
    drive(1, 1, 32'h20 ^ K, 1, 0, 32'h0);
    chk("flush_still_empty", 32'(inst_valid), 32'd0);
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    chk("flush_pc", inst_pc, 32'h20);
    chk("flush_data", inst_data, 32'h20 ^ K);

    // two redirects while dropping, then a misaligned redirect, then PC wrap
    do_reset();
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    drive(1, 0, 32'h0, 1, 1, 32'h10);
    drive(1, 0, 32'h0, 1, 1, 32'h30);
    chk("drop2_addr", imem_addr, 32'h0);
    drive(1, 1, 32'hBAD0_BAD0, 1, 0, 32'h0);
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    chk("drop2_latest", imem_addr, 32'h30);
    chk("drop2_valid", 32'(inst_valid), 32'd0);
    drive(1, 1, 32'hBAD1_BAD1, 1, 1, 32'h23);
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    chk("align_addr", imem_addr, 32'h20);
    chk("align_valid", 32'(inst_valid), 32'd0);
    drive(1, 1, 32'hBAD2_BAD2, 1, 1, 32'hFFFF_FFFF);
    drive(1, 1, 32'h0000_0005, 1, 0, 32'h0);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    chk("wrap_addr_zero", imem_addr, 32'h0);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_data", inst_data, 32'h0000_0005);

    // reset while a request is outstanding, with a late ack during reset
    do_reset();
    drive(1, 1, 32'h00 ^ K, 0, 0, 32'h0);
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    chk("rst_pre_valid", 32'(inst_valid), 32'd1);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    chk("rst_req_low", 32'(imem_req), 32'd0);
    drive(0, 1, 32'h1234_5678, 0, 0, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_data", inst_data, 32'h0);
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    chk("rst_no_push", 32'(inst_valid), 32'd0);
    chk("rst_restart_req", 32'(imem_req), 32'd1);
    chk("rst_restart_addr", imem_addr, 32'h0);
    drive(1, 1, 32'h00 ^ K, 1, 0, 32'h0);
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    chk("rst_first_pc", inst_pc, 32'h0);
    chk("rst_first_data", inst_data, 32'h00 ^ K);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
- Instruction fetch front-end that sits directly upstream of the single-cycle MIPS-lite datapath.
- Issues word reads to instruction memory over a req/ack interface and buffers returned words with their PCs in a small FIFO.
- Presents instructions to the datapath with a valid/ready handshake.
- Accepts PC redirects (branch, jump, jr-type, link targets), which flush the buffer and any in-flight fetch.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- imem_req, output, 1, read request; held until accepted.
- imem_addr, output, 32, word-aligned fetch address; stable while imem_req=1.
- imem_ack, input, 1, request completes in the cycle where imem_req&&imem_ack.
- imem_rdata, input, 32, instruction word; valid in the ack cycle.
- inst_valid, output, 1, FIFO head valid.
- inst_data, output, 32, FIFO head instruction.
- inst_pc, output, 32, PC of the head instruction.
- inst_ready, input, 1, datapath consumes the head when inst_valid&&inst_ready.
- redirect_valid, input, 1, PC redirect this cycle.
- redirect_pc, input, 32, new fetch PC; bits [1:0] are forced to 0.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, port rst_n.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, fetch_pc=RESET_PC, FIFO count=0.
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0.
  - Reset mid-transaction abandons the transaction; an ack arriving after reset is ignored.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, result wanted.
  - DROP: request outstanding, result to be discarded.
- IDLE -> WAIT when count<DEPTH and no redirect. imem_req=1 and imem_addr=fetch_pc from the same cycle (Mealy).
- WAIT, ack without redirect:
  - Push {fetch_pc, imem_rdata}; fetch_pc+=4.
  - Go to WAIT if count after push and pop < DEPTH, otherwise IDLE (back-to-back fetch allowed).
- WAIT, redirect without ack: go to DROP and latch fetch_pc=redirect_pc. imem_req stays 1 and imem_addr stays unchanged until ack; the protocol forbids abandoning a request.
- WAIT, redirect and ack in the same cycle: data is discarded, fetch_pc=redirect_pc, go to IDLE.
- DROP, ack: discard data, go to IDLE. A further redirect while in DROP overwrites fetch_pc; the latest redirect wins.
- Redirect in any state: FIFO flushed (count=0) at the next edge; inst_valid=0 the cycle after the redirect.
- Redirect has priority over a simultaneous pop and over a simultaneous push.
- FIFO:
  - Registered head; fall-through latency is 1 cycle (ack at edge N gives inst_valid after edge N).
  - Simultaneous push and pop at count=DEPTH is allowed only if a request was outstanding.
  - Requests are never issued when count=DEPTH, so a full FIFO never overflows.
  - Pop on empty is ignored.
- fetch_pc wraps modulo 2^32: 32'hFFFF_FFFC+4 = 0.
- Throughput: with zero-wait memory (ack asserted with req) and inst_ready=1, one instruction per cycle sustained.

Decomposition:
- Shared package ifetch_pkg: state encodings IF_IDLE/IF_WAIT/IF_DROP, INST_W=32, the PC increment constant 4, and the fifo entry layout {pc[31:0], inst[31:0]}.
- Sub-module ifetch_fifo: parameterised DEPTH, 64-bit entries, with push, pop, flush, count, full and empty.
- The top level holds the FSM, fetch_pc and the redirect logic.

Test Plan:
- Reset, zero-wait memory returning word=addr^32'hA5A5_A5A5, inst_ready=1 -> inst_pc sequence 0,4,8,12 on consecutive cycles from cycle 2; inst_data matches; imem_req=0 during reset.
- inst_ready=0 with DEPTH=4 -> exactly 4 accepted requests, imem_req=0 afterwards; release ready -> 4 pops in order PC 0..12, then fetching resumes at 16.
- 3-cycle memory latency, redirect_pc=32'h40 asserted 1 cycle after req -> original request stays held until ack, its data is dropped, next imem_addr=32'h40, first inst_pc=32'h40.
- Redirect to 32'h20 in the same cycle as ack and inst_ready pop with 2 entries buffered -> FIFO empty next cycle, no entry from the old stream ever appears, next fetch at 32'h20.
- Two redirects (32'h10, then 32'h30) during DROP -> only 32'h30 is fetched; redirect_pc=32'h23 -> fetch at 32'h20.
- Reset asserted while WAIT, with a late ack -> all outputs at reset values, no push, fetch restarts at RESET_PC.
